// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, ARM condition codes and issue-controller states.
// Used by the issue controller, the condition evaluator and the branch unit.
package alu_pkg;

   localparam logic [4:0] OP_AND   = 5'd0;
   localparam logic [4:0] OP_EOR   = 5'd1;
   localparam logic [4:0] OP_SUB   = 5'd2;
   localparam logic [4:0] OP_RSB   = 5'd3;
   localparam logic [4:0] OP_ADD   = 5'd4;
   localparam logic [4:0] OP_ADC   = 5'd5;
   localparam logic [4:0] OP_SBC   = 5'd6;
   localparam logic [4:0] OP_RSC   = 5'd7;
   localparam logic [4:0] OP_TST   = 5'd8;
   localparam logic [4:0] OP_TEQ   = 5'd9;
   localparam logic [4:0] OP_CMP   = 5'd10;
   localparam logic [4:0] OP_CMN   = 5'd11;
   localparam logic [4:0] OP_ORR   = 5'd12;
   localparam logic [4:0] OP_MOV   = 5'd13;
   localparam logic [4:0] OP_BIC   = 5'd14;
   localparam logic [4:0] OP_MVN   = 5'd15;
   localparam logic [4:0] OP_PASSA = 5'd16;
   localparam logic [4:0] OP_A4    = 5'd17;
   localparam logic [4:0] OP_AB4   = 5'd18;
   localparam logic [4:0] OP_AMB4  = 5'd19;
   localparam logic [4:0] OP_A1    = 5'd20;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-field evaluator: decides whether an instruction executes given the current NZCV.
// Purely combinational so it can be shared with the branch unit.
module cond_eval
   import alu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic flagN, flagZ, flagC, flagV;

   assign flagN = nzcv[3];
   assign flagZ = nzcv[2];
   assign flagC = nzcv[1];
   assign flagV = nzcv[0];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = flagZ;
         COND_NE: pass = !flagZ;
         COND_CS: pass = flagC;
         COND_CC: pass = !flagC;
         COND_MI: pass = flagN;
         COND_PL: pass = !flagN;
         COND_VS: pass = flagV;
         COND_VC: pass = !flagV;
         COND_HI: pass = flagC && !flagZ;
         COND_LS: pass = !flagC || flagZ;
         COND_GE: pass = (flagN == flagV);
         COND_LT: pass = (flagN != flagV);
         COND_GT: pass = !flagZ && (flagN == flagV);
         COND_LE: pass = flagZ || (flagN != flagV);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one combinational ALU between execute (port 0) and fetch (port 1): arbitrates, issues,
// applies the condition field, registers the result and owns the NZCV flags.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DW     = 32,
   parameter int OPW    = 5,
   parameter int STARVE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [2*DW-1:0]   req_a,
   input  logic [2*DW-1:0]   req_b,
   input  logic [2*OPW-1:0]  req_op,
   input  logic [1:0]        req_s,
   input  logic [7:0]        req_cond,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_port,
   output logic [DW-1:0]     rsp_data,
   output logic              rsp_skipped,
   output logic [3:0]        flags_nzcv,
   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   output logic [OPW-1:0]    alu_op,
   output logic              alu_cin,
   output logic              alu_s,
   input  logic [DW-1:0]     alu_out,
   input  logic              alu_c,
   input  logic              alu_z,
   input  logic              alu_n,
   input  logic              alu_v
);

   localparam int CW = $clog2(STARVE + 1);

   state_t           stateQ, stateD;
   logic [DW-1:0]    opA, opB;
   logic [OPW-1:0]   opCode;
   logic             opS;
   logic [3:0]       opCond;
   logic             opPort;
   logic             rrPtr;
   logic [CW-1:0]    starveCnt;
   logic             grantAny;
   logic             grantPort;
   logic             starved;
   logic             condPass;

   cond_eval uCondEval (
      .cond (opCond),
      .nzcv (flags_nzcv),
      .pass (condPass)
   );

   assign starved = (starveCnt >= CW'(STARVE));

   // Round-robin between both ports, overridden once port 1 has waited STARVE grants.
   always_comb begin
      grantAny  = (stateQ == ST_IDLE) && (req_valid != 2'b00);
      grantPort = 1'b0;
      case (req_valid)
         2'b01:   grantPort = 1'b0;
         2'b10:   grantPort = 1'b1;
         2'b11:   grantPort = starved ? 1'b1 : rrPtr;
         default: grantPort = 1'b0;
      endcase
      req_ready = 2'b00;
      if (grantAny) begin
         req_ready = grantPort ? 2'b10 : 2'b01;
      end
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         ST_IDLE:  if (grantAny) stateD = ST_ISSUE;
         ST_ISSUE: stateD = ST_RESP;
         ST_RESP:  if (rsp_ready) stateD = ST_IDLE;
         default:  stateD = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ <= ST_IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         opA         <= '0;
         opB         <= '0;
         opCode      <= '0;
         opS         <= 1'b0;
         opCond      <= 4'h0;
         opPort      <= 1'b0;
         rrPtr       <= 1'b0;
         starveCnt   <= '0;
         rsp_valid   <= 1'b0;
         rsp_port    <= 1'b0;
         rsp_data    <= '0;
         rsp_skipped <= 1'b0;
         flags_nzcv  <= 4'h0;
      end else begin
         case (stateQ)
            ST_IDLE: begin
               if (grantAny) begin
                  opA    <= grantPort ? req_a[2*DW-1:DW]    : req_a[DW-1:0];
                  opB    <= grantPort ? req_b[2*DW-1:DW]    : req_b[DW-1:0];
                  opCode <= grantPort ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
                  opS    <= grantPort ? req_s[1]            : req_s[0];
                  opCond <= grantPort ? req_cond[7:4]       : req_cond[3:0];
                  opPort <= grantPort;
                  rrPtr  <= ~rrPtr;
                  if (grantPort) begin
                     starveCnt <= '0;
                  end else if (req_valid[1] && !starved) begin
                     starveCnt <= starveCnt + 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               rsp_valid <= 1'b1;
               rsp_port  <= opPort;
               if (condPass) begin
                  rsp_data    <= alu_out;
                  rsp_skipped <= 1'b0;
                  if (opS) begin
                     flags_nzcv <= {alu_n, alu_z, alu_c, alu_v};
                  end
               end else begin
                  rsp_data    <= '0;
                  rsp_skipped <= 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Operands are presented straight from the latched request; only S is gated to the issue cycle.
   assign alu_a   = opA;
   assign alu_b   = opB;
   assign alu_op  = opCode;
   assign alu_s   = (stateQ == ST_ISSUE) && opS;
   assign alu_cin = flags_nzcv[1];

endmodule
